// File: rtl/d8m_stream_capture.sv
// D8M parallel-pixel capture: turns FVAL/LVAL-framed pixels into one Avalon-ST VIP packet per
// frame (header beat + kept pixels), with decimation, skid FIFO, geometry and sticky errors.
module d8m_stream_capture #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int DECIM      = 1,
  parameter int CNT_W      = 12
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cfg_enable,
  input  logic [DATA_W-1:0] cam_d,
  input  logic              cam_fval,
  input  logic              cam_lval,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [CNT_W-1:0]  frame_width,
  output logic [CNT_W-1:0]  frame_height,
  output logic [15:0]       frame_count,
  output logic              err_overflow,
  output logic              err_geometry,
  input  logic              err_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DATA_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'(DECIM - 1);
  localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_ACTIVE = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  state_t            state_q, state_d;
  logic              fval_prev_q, lval_prev_q;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  line_kept_q, line_kept_d;
  logic [CNT_W-1:0]  kept_rows_q, kept_rows_d;
  logic [CNT_W-1:0]  ref_w_q, ref_w_d;
  logic              ref_valid_q, ref_valid_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [CNT_W-1:0]  height_q, height_d;
  logic [15:0]       count_q, count_d;
  logic              err_ovf_q, err_geo_q;

  logic [FW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;

  logic              fifo_empty_s, fifo_full_s, pop_s, can_push_s;
  logic [FW-1:0]     head_s;
  logic              push_s;
  logic [FW-1:0]     push_word_s;
  logic              ovf_set_s, geo_set_s;
  logic              pix_valid_s, lval_fall_s, fval_rise_s, keep_s;
  logic [CNT_W-1:0]  width_next_s, height_next_s;

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s        = !fifo_empty_s && out_ready;
  // A pop in the same cycle frees the slot a push needs.
  assign can_push_s   = !fifo_full_s || pop_s;
  assign head_s       = mem_q[rd_ptr_q[AW-1:0]];

  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_empty_s ? {DATA_W{1'b0}} : head_s[DATA_W-1:0];
  assign out_sop   = !fifo_empty_s && head_s[FW-1];
  assign out_eop   = !fifo_empty_s && head_s[FW-2];

  assign frame_width  = width_q;
  assign frame_height = height_q;
  assign frame_count  = count_q;
  assign err_overflow = err_ovf_q;
  assign err_geometry = err_geo_q;

  assign pix_valid_s = cam_fval && cam_lval;
  assign lval_fall_s = lval_prev_q && !cam_lval;
  assign fval_rise_s = cam_fval && !fval_prev_q;
  assign keep_s      = pix_valid_s && ((col_q & DEC_MASK) == {CNT_W{1'b0}}) &&
                       ((row_q & DEC_MASK) == {CNT_W{1'b0}});

  // Geometry as it stands if the frame closes this cycle (covers a line ending on the same edge).
  assign width_next_s  = ref_valid_q ? ref_w_q :
                         (lval_fall_s ? line_kept_q : {CNT_W{1'b0}});
  assign height_next_s = (lval_fall_s && (line_kept_q != {CNT_W{1'b0}})) ?
                         sat_inc(kept_rows_q) : kept_rows_q;

  // Next-state, counter, hold-register and FIFO-push decisions.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    line_kept_d  = line_kept_q;
    kept_rows_d  = kept_rows_q;
    ref_w_d      = ref_w_q;
    ref_valid_d  = ref_valid_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    width_d      = width_q;
    height_d     = height_q;
    count_d      = count_q;
    push_s       = 1'b0;
    push_word_s  = {FW{1'b0}};
    ovf_set_s    = 1'b0;
    geo_set_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fval_rise_s && cfg_enable) begin
          state_d = S_HEADER;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HEADER: begin
        col_d        = {CNT_W{1'b0}};
        row_d        = {CNT_W{1'b0}};
        line_kept_d  = {CNT_W{1'b0}};
        kept_rows_d  = {CNT_W{1'b0}};
        ref_w_d      = {CNT_W{1'b0}};
        ref_valid_d  = 1'b0;
        hold_valid_d = 1'b0;
        if (can_push_s) begin
          push_s      = 1'b1;
          push_word_s = {1'b1, 1'b0, {DATA_W{1'b0}}};
          state_d     = S_ACTIVE;
        end else begin
          state_d = S_HEADER;
        end
      end

      S_ACTIVE: begin
        if (lval_fall_s) begin
          col_d       = {CNT_W{1'b0}};
          row_d       = sat_inc(row_q);
          line_kept_d = {CNT_W{1'b0}};
          // Decimated-away rows have no kept pixels and take no part in the width check.
          if (line_kept_q != {CNT_W{1'b0}}) begin
            kept_rows_d = sat_inc(kept_rows_q);
            if (!ref_valid_q) begin
              ref_w_d     = line_kept_q;
              ref_valid_d = 1'b1;
            end else if (line_kept_q != ref_w_q) begin
              geo_set_s = 1'b1;
            end else begin
              geo_set_s = 1'b0;
            end
          end else begin
            kept_rows_d = kept_rows_q;
          end
        end else if (pix_valid_s) begin
          col_d = sat_inc(col_q);
          if (keep_s) begin
            line_kept_d = sat_inc(line_kept_q);
          end else begin
            line_kept_d = line_kept_q;
          end
        end else begin
          col_d = col_q;
        end

        if (!cam_fval) begin
          // Frame over: close the packet as soon as there is room for the eop beat.
          if (can_push_s) begin
            push_s       = 1'b1;
            push_word_s  = {1'b0, 1'b1, hold_valid_q ? hold_data_q : {DATA_W{1'b0}}};
            hold_valid_d = 1'b0;
            width_d      = width_next_s;
            height_d     = height_next_s;
            count_d      = count_q + 16'd1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_ACTIVE;
          end
        end else if (keep_s) begin
          if (!can_push_s) begin
            ovf_set_s    = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = S_DROP;
          end else begin
            push_s       = hold_valid_q;
            push_word_s  = {1'b0, 1'b0, hold_data_q};
            hold_data_d  = cam_d;
            hold_valid_d = 1'b1;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end

      S_DROP: begin
        hold_valid_d = 1'b0;
        if (!cam_fval && can_push_s) begin
          push_s      = 1'b1;
          push_word_s = {1'b0, 1'b1, {DATA_W{1'b0}}};
          count_d     = count_q + 16'd1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, FIFO pointers and sticky flags.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= S_IDLE;
      // Treat fval as already high so a frame in progress at reset release is skipped.
      fval_prev_q  <= 1'b1;
      lval_prev_q  <= 1'b0;
      col_q        <= {CNT_W{1'b0}};
      row_q        <= {CNT_W{1'b0}};
      line_kept_q  <= {CNT_W{1'b0}};
      kept_rows_q  <= {CNT_W{1'b0}};
      ref_w_q      <= {CNT_W{1'b0}};
      ref_valid_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= {DATA_W{1'b0}};
      width_q      <= {CNT_W{1'b0}};
      height_q     <= {CNT_W{1'b0}};
      count_q      <= 16'd0;
      err_ovf_q    <= 1'b0;
      err_geo_q    <= 1'b0;
      wr_ptr_q     <= {(AW+1){1'b0}};
      rd_ptr_q     <= {(AW+1){1'b0}};
    end else begin
      state_q      <= state_d;
      fval_prev_q  <= cam_fval;
      lval_prev_q  <= cam_lval;
      col_q        <= col_d;
      row_q        <= row_d;
      line_kept_q  <= line_kept_d;
      kept_rows_q  <= kept_rows_d;
      ref_w_q      <= ref_w_d;
      ref_valid_q  <= ref_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      width_q      <= width_d;
      height_q     <= height_d;
      count_q      <= count_d;
      // A new error outranks a coincident clear.
      err_ovf_q    <= ovf_set_s || (err_ovf_q && !err_clear);
      err_geo_q    <= geo_set_s || (err_geo_q && !err_clear);
      wr_ptr_q     <= push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_q     <= pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_word_s;
    end
  end

endmodule

// File: tb/tb_d8m_stream_capture.sv
// Directed bench: one DECIM=1 and one DECIM=2 instance share stimulus; beats are collected
// per instance and compared against hand-computed packets.
module tb_d8m_stream_capture;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        cfg_enable;
  logic [11:0] cam_d;
  logic        cam_fval, cam_lval;
  logic        out_ready;
  logic        err_clear;

  logic [11:0] d1_data, d2_data;
  logic        d1_valid, d2_valid, d1_sop, d2_sop, d1_eop, d2_eop;
  logic [11:0] d1_w, d2_w, d1_h, d2_h;
  logic [15:0] d1_cnt, d2_cnt;
  logic        d1_ovf, d2_ovf, d1_geo, d2_geo;

  logic [13:0] q1[$];
  logic [13:0] q2[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d8m_stream_capture #(.DATA_W(12), .FIFO_DEPTH(16), .DECIM(1), .CNT_W(12)) dut1 (
    .clk_clk(clk), .reset_reset(reset_reset), .cfg_enable(cfg_enable), .cam_d(cam_d),
    .cam_fval(cam_fval), .cam_lval(cam_lval), .out_data(d1_data), .out_valid(d1_valid),
    .out_ready(out_ready), .out_sop(d1_sop), .out_eop(d1_eop), .frame_width(d1_w),
    .frame_height(d1_h), .frame_count(d1_cnt), .err_overflow(d1_ovf),
    .err_geometry(d1_geo), .err_clear(err_clear));

  d8m_stream_capture #(.DATA_W(12), .FIFO_DEPTH(16), .DECIM(2), .CNT_W(12)) dut2 (
    .clk_clk(clk), .reset_reset(reset_reset), .cfg_enable(cfg_enable), .cam_d(cam_d),
    .cam_fval(cam_fval), .cam_lval(cam_lval), .out_data(d2_data), .out_valid(d2_valid),
    .out_ready(out_ready), .out_sop(d2_sop), .out_eop(d2_eop), .frame_width(d2_w),
    .frame_height(d2_h), .frame_count(d2_cnt), .err_overflow(d2_ovf),
    .err_geometry(d2_geo), .err_clear(err_clear));

  // Record every accepted beat mid-cycle, when inputs and outputs are stable.
  always @(negedge clk) begin
    if (d1_valid && out_ready) q1.push_back({d1_sop, d1_eop, d1_data});
    if (d2_valid && out_ready) q2.push_back({d2_sop, d2_eop, d2_data});
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] b1(input int i);
    if (i < q1.size()) return q1[i];
    return 14'h3FFF;
  endfunction

  function automatic logic [13:0] b2(input int i);
    if (i < q2.size()) return q2[i];
    return 14'h3FFF;
  endfunction

  function automatic logic [13:0] pix(input int r, input int c, input bit eop);
    logic [11:0] d;
    d = 12'(256 + r * 16 + c);
    return {1'b0, eop, d};
  endfunction

  // Frame of nl lines: all lines w pixels except the last, which has lw.
  task automatic frame(input int nl, input int w, input int lw);
    cam_fval = 1'b1;
    tick(3);
    for (int r = 0; r < nl; r++) begin
      cam_lval = 1'b1;
      for (int c = 0; c < ((r == nl - 1) ? lw : w); c++) begin
        cam_d = 12'(256 + r * 16 + c);
        tick(1);
      end
      cam_lval = 1'b0;
      cam_d    = 12'h000;
      tick(2);
    end
    cam_fval = 1'b0;
    tick(4);
  endtask

  initial begin
    reset_reset = 1'b1;
    cfg_enable  = 1'b1;
    cam_d       = 12'h000;
    cam_fval    = 1'b0;
    cam_lval    = 1'b0;
    out_ready   = 1'b1;
    err_clear   = 1'b0;
    tick(3);
    reset_reset = 1'b0;
    tick(1);

    // Reset state
    chk("rst_valid", d1_valid, 0);
    chk("rst_data", d1_data, 0);
    chk("rst_sop_eop", {d1_sop, d1_eop}, 0);
    chk("rst_width", d1_w, 0);
    chk("rst_height", d1_h, 0);
    chk("rst_count", d1_cnt, 0);
    chk("rst_errs", {d1_ovf, d1_geo}, 0);

    // T1: 4x2, DECIM=1
    q1.delete(); q2.delete();
    frame(2, 4, 4);
    tick(6);
    chk("t1_beats", q1.size(), 9);
    chk("t1_header", b1(0), 14'h2000);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t1_pix%0d", k), b1(k + 1), pix(k / 4, k % 4, k == 7));
    chk("t1_width", d1_w, 4);
    chk("t1_height", d1_h, 2);
    chk("t1_count", d1_cnt, 1);

    // T2: 8x4, DECIM=2 keeps cols 0,2,4,6 of rows 0,2
    q1.delete(); q2.delete();
    frame(4, 8, 8);
    tick(6);
    chk("t2_beats", q2.size(), 9);
    chk("t2_header", b2(0), 14'h2000);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_pix%0d", k), b2(k + 1), pix(2 * (k / 4), 2 * (k % 4), k == 7));
    chk("t2_width", d2_w, 4);
    chk("t2_height", d2_h, 2);
    chk("t2_count", d2_cnt, 2);
    chk("t2_full_width", d1_w, 8);
    chk("t2_full_height", d1_h, 4);

    // T3: sink stalled through a 64-pixel line
    q1.delete(); q2.delete();
    out_ready = 1'b0;
    frame(1, 64, 64);
    chk("t3_ovf", d1_ovf, 1);
    chk("t3_valid_held", d1_valid, 1);
    chk("t3_no_beats", q1.size(), 0);
    out_ready = 1'b1;
    tick(25);
    chk("t3_beats", q1.size(), 17);
    chk("t3_header", b1(0), 14'h2000);
    chk("t3_last_pix", b1(15), pix(0, 14, 1'b0));
    chk("t3_eop_beat", b1(16), 14'h1000);
    chk("t3_count", d1_cnt, 3);
    chk("t3_width_kept", d1_w, 8);
    chk("t3_height_kept", d1_h, 4);
    chk("t3_geo", d1_geo, 0);

    // T4: lines 4,4,3 then error clear and a clean frame
    q1.delete(); q2.delete();
    frame(3, 4, 3);
    tick(6);
    chk("t4_geo", d1_geo, 1);
    chk("t4_beats", q1.size(), 12);
    chk("t4_eop", b1(11), pix(2, 2, 1'b1));
    chk("t4_width", d1_w, 4);
    chk("t4_height", d1_h, 3);
    chk("t4_count", d1_cnt, 4);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
    chk("t4_clr_geo", d1_geo, 0);
    chk("t4_clr_ovf", d1_ovf, 0);
    frame(2, 4, 4);
    tick(6);
    chk("t4_clean_geo", d1_geo, 0);
    chk("t4_clean_count", d1_cnt, 5);

    // T5: reset mid-line
    cam_fval = 1'b1;
    tick(3);
    cam_lval = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cam_d = 12'(256 + c);
      tick(1);
    end
    reset_reset = 1'b1;
    cam_d = 12'h103;
    tick(1);
    chk("t5_valid", d1_valid, 0);
    chk("t5_count", d1_cnt, 0);
    chk("t5_width", d1_w, 0);
    chk("t5_height", d1_h, 0);
    chk("t5_errs", {d1_ovf, d1_geo}, 0);
    reset_reset = 1'b0;
    q1.delete(); q2.delete();
    cam_d = 12'h104;
    tick(1);
    cam_lval = 1'b0;
    tick(2);
    cam_fval = 1'b0;
    tick(4);
    chk("t5_partial_ignored", q1.size(), 0);
    frame(2, 4, 4);
    tick(6);
    chk("t5_beats", q1.size(), 9);
    chk("t5_sop_first", b1(0), 14'h2000);
    chk("t5_count_after", d1_cnt, 1);

    // T6: enable raised mid-frame
    q1.delete(); q2.delete();
    cfg_enable = 1'b0;
    cam_fval = 1'b1;
    tick(1);
    cfg_enable = 1'b1;
    tick(2);
    for (int r = 0; r < 2; r++) begin
      cam_lval = 1'b1;
      for (int c = 0; c < 4; c++) begin
        cam_d = 12'(256 + r * 16 + c);
        tick(1);
      end
      cam_lval = 1'b0;
      tick(2);
    end
    cam_fval = 1'b0;
    tick(6);
    chk("t6_no_beats", q1.size(), 0);
    chk("t6_count_same", d1_cnt, 1);
    frame(2, 4, 4);
    tick(6);
    chk("t6_next_beats", q1.size(), 9);
    chk("t6_next_eop", b1(8), pix(1, 3, 1'b1));
    chk("t6_next_count", d1_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
